// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives a 3-input combinational stage through all eight input vectors,
// lets each vector settle, majority-votes the synchronized stage output and
// assembles the observed truth table (bit 7-v holds the response to vector v).
// The finished table is compared against EXPECTED to produce pass.
module truth_table_sweeper #(
    parameter int         SETTLE_CYCLES = 16,
    parameter int         SAMPLES       = 3,
    parameter logic [7:0] EXPECTED      = 8'h4A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       pass
);

    // Settle counter spans 0..SETTLE_CYCLES-1 (SETTLE_CYCLES >= 2, so at least 1 bit).
    localparam int SET_W = $clog2(SETTLE_CYCLES);
    // Ones counter must hold SAMPLES; the sample index counter fits in the same width.
    localparam int SMP_W = $clog2(SAMPLES + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES - 1);
    localparam logic [SMP_W-1:0] HALF     = SMP_W'(SAMPLES / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [2:0]       v_q,       v_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [SMP_W-1:0] ones_q,    ones_d;
    logic [7:0]       table_q,   table_d;
    logic             pass_q,    pass_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             sync1_q,   sync2_q;
    logic [SMP_W-1:0] ones_sum;

    // Two-flop synchronizer for the asynchronous stage output; runs in every state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= dut_out;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: sequencing, counters, vote and table assembly.
    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        set_cnt_d = set_cnt_q;
        smp_cnt_d = smp_cnt_q;
        ones_d    = ones_q;
        table_d   = table_q;
        pass_d    = pass_q;
        // Running count including the current sample; never exceeds SAMPLES.
        ones_sum  = ones_q + SMP_W'(sync2_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    v_d       = 3'd0;
                    set_cnt_d = '0;
                    smp_cnt_d = '0;
                    ones_d    = '0;
                    table_d   = 8'h00;
                    pass_d    = 1'b0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    set_cnt_d = '0;
                    state_d   = SAMPLE;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (smp_cnt_q == SMP_LAST) begin
                    table_d[3'd7 - v_q] = (ones_sum > HALF);
                    smp_cnt_d = '0;
                    ones_d    = '0;
                    if (v_q == 3'd7) begin
                        // Inputs return to 000 once the sweep is over.
                        v_d     = 3'd0;
                        pass_d  = (table_d == EXPECTED);
                        state_d = DONE;
                    end else begin
                        v_d     = v_q + 3'd1;
                        state_d = SETTLE;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    ones_d    = ones_sum;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            v_q       <= 3'd0;
            set_cnt_q <= '0;
            smp_cnt_q <= '0;
            ones_q    <= '0;
            table_q   <= 8'h00;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            set_cnt_q <= set_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            ones_q    <= ones_d;
            table_q   <= table_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in1         = v_q[2];
    assign in2         = v_q[1];
    assign in3         = v_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = table_q;
    assign pass        = pass_q;

endmodule
